// File: rtl/rv32im_pkg.sv
// Shared encodings for the RV32IM decode/execute slice: opcodes, ALU select
// codes, immediate/writeback/branch encodings and the ID/EX payload.
package rv32im_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // {M, alt, funct3}
    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SLL    = 5'b00001,
        ALU_SLT    = 5'b00010,
        ALU_SLTU   = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SRL    = 5'b00101,
        ALU_OR     = 5'b00110,
        ALU_AND    = 5'b00111,
        ALU_SUB    = 5'b01000,
        ALU_SRA    = 5'b01101,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111,
        ALU_FWD    = 5'b11000
    } alu_sel_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    // branch[3] = valid, low bits = funct3 for conditional branches
    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_JUMP = 4'b1010;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            we;
        logic [2:0]      mem_write;
        logic [3:0]      mem_read;
        logic [1:0]      wb_sel;
        alu_sel_e        alu_sel;
        logic [3:0]      branch;
        logic            op1_sel;
        logic            op2_sel;
    } id_ex_t;

endpackage

// File: rtl/rv32im_decode_execute_if.sv
// Bus between the ID/EX-side pipeline and the decode/execute slice.
// slave  : the decode/execute block (takes ID values, drives decode selects and EX outputs)
// master : the surrounding pipeline / testbench
interface rv32im_decode_execute_if;
    logic        FLUSH;
    logic [31:0] ID_INSTRUCTION;
    logic [31:0] ID_PC;
    logic [31:0] ID_REG_DATA1;
    logic [31:0] ID_REG_DATA2;
    logic [31:0] ID_IMMEDIATE;
    logic [2:0]  ID_IMMEDIATE_SELECT;
    logic        ID_OPERAND1_SELECT;
    logic        ID_OPERAND2_SELECT;
    logic [31:0] EX_PC;
    logic [31:0] EX_REG_DATA2;
    logic [4:0]  EX_REG_WRITE_ADDR;
    logic        EX_REG_WRITE_EN;
    logic [2:0]  EX_DATA_MEM_WRITE;
    logic [3:0]  EX_DATA_MEM_READ;
    logic [1:0]  EX_WB_VALUE_SELECT;
    logic [31:0] EX_ALU_OUT;
    logic        EX_BJ_SIG;

    modport slave (
        input  FLUSH, ID_INSTRUCTION, ID_PC, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE,
        output ID_IMMEDIATE_SELECT, ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
        output EX_PC, EX_REG_DATA2, EX_REG_WRITE_ADDR, EX_REG_WRITE_EN,
        output EX_DATA_MEM_WRITE, EX_DATA_MEM_READ, EX_WB_VALUE_SELECT,
        output EX_ALU_OUT, EX_BJ_SIG
    );

    modport master (
        output FLUSH, ID_INSTRUCTION, ID_PC, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE,
        input  ID_IMMEDIATE_SELECT, ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
        input  EX_PC, EX_REG_DATA2, EX_REG_WRITE_ADDR, EX_REG_WRITE_EN,
        input  EX_DATA_MEM_WRITE, EX_DATA_MEM_READ, EX_WB_VALUE_SELECT,
        input  EX_ALU_OUT, EX_BJ_SIG
    );
endinterface

// File: rtl/rv32im_alu_core.sv
// Purely combinational RV32IM ALU.
// Ports: op1, op2 (operands), alu_sel (ALU_SELECT code), result.
module rv32im_alu_core
    import rv32im_pkg::*;
(
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  alu_sel_e        alu_sel,
    output logic [XLEN-1:0] result
);

    logic        a_signed;
    logic        b_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] sdiv;
    logic [31:0] srem;

    // One 64-bit multiplier covers all MUL variants via operand extension
    always_comb begin
        a_signed = (alu_sel == ALU_MULH) || (alu_sel == ALU_MULHSU);
        b_signed = (alu_sel == ALU_MULH);
        a_ext    = {{32{a_signed & op1[31]}}, op1};
        b_ext    = {{32{b_signed & op2[31]}}, op2};
        product  = a_ext * b_ext;
    end

    always_comb begin
        div_zero = (op2 == 32'h0);
        div_ovf  = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
        sdiv     = 32'h0;
        srem     = 32'h0;
        if (!div_zero && !div_ovf) begin
            sdiv = 32'($signed(op1) / $signed(op2));
            srem = 32'($signed(op1) % $signed(op2));
        end
    end

    always_comb begin
        result = 32'h0;
        case (alu_sel)
            ALU_ADD:    result = op1 + op2;
            ALU_SUB:    result = op1 - op2;
            ALU_SLL:    result = op1 << op2[4:0];
            ALU_SLT:    result = {31'h0, $signed(op1) < $signed(op2)};
            ALU_SLTU:   result = {31'h0, op1 < op2};
            ALU_XOR:    result = op1 ^ op2;
            ALU_SRL:    result = op1 >> op2[4:0];
            ALU_SRA:    result = 32'($signed(op1) >>> op2[4:0]);
            ALU_OR:     result = op1 | op2;
            ALU_AND:    result = op1 & op2;
            ALU_MUL:    result = product[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result = product[63:32];
            ALU_DIV:    result = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : sdiv);
            ALU_DIVU:   result = div_zero ? 32'hFFFF_FFFF : op1 / op2;
            ALU_REM:    result = div_zero ? op1 : (div_ovf ? 32'h0 : srem);
            ALU_REMU:   result = div_zero ? op1 : op1 % op2;
            ALU_FWD:    result = op2;
            default:    result = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32im_decode_execute.sv
// RV32IM decode/execute slice: ID control decode, ID/EX register, EX ALU and
// branch decision.
// Ports: CLK, RESET (sync, active-high); bus (slave) carries FLUSH and the ID
// operands in, the ID immediate/operand selects and the registered EX fields out.
module rv32im_decode_execute
    import rv32im_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    rv32im_decode_execute_if.slave bus
);

    id_ex_t      id_ex_d;
    id_ex_t      id_ex_q;
    logic [2:0]  imm_sel;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] alu_out;
    logic        bj_sig;
    logic        unused_instr_bits;

    assign opcode = bus.ID_INSTRUCTION[6:0];
    assign funct3 = bus.ID_INSTRUCTION[14:12];
    assign unused_instr_bits = ^{bus.ID_INSTRUCTION[31], bus.ID_INSTRUCTION[29:26],
                                 bus.ID_INSTRUCTION[24:15]};

    // Control decode; FLUSH turns the next ID/EX contents into a bubble
    always_comb begin
        id_ex_d         = '0;
        imm_sel         = IMM_I;
        id_ex_d.pc      = bus.ID_PC;
        id_ex_d.rs1     = bus.ID_REG_DATA1;
        id_ex_d.rs2     = bus.ID_REG_DATA2;
        id_ex_d.imm     = bus.ID_IMMEDIATE;
        id_ex_d.rd      = bus.ID_INSTRUCTION[11:7];
        id_ex_d.alu_sel = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                id_ex_d.alu_sel = ALU_FWD;
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_U;
                id_ex_d.wb_sel  = WB_ALU;
                id_ex_d.we      = 1'b1;
            end
            OPC_AUIPC: begin
                id_ex_d.op1_sel = 1'b1;
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_U;
                id_ex_d.wb_sel  = WB_ALU;
                id_ex_d.we      = 1'b1;
            end
            OPC_JAL: begin
                id_ex_d.op1_sel = 1'b1;
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_J;
                id_ex_d.wb_sel  = WB_PC4;
                id_ex_d.we      = 1'b1;
                id_ex_d.branch  = BR_JUMP;
            end
            OPC_JALR: begin
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_I;
                id_ex_d.wb_sel  = WB_PC4;
                id_ex_d.we      = 1'b1;
                id_ex_d.branch  = BR_JUMP;
            end
            OPC_BRANCH: begin
                id_ex_d.op1_sel = 1'b1;
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_B;
                id_ex_d.branch  = {1'b1, funct3};
            end
            OPC_LOAD: begin
                id_ex_d.op2_sel  = 1'b1;
                imm_sel          = IMM_I;
                id_ex_d.mem_read = {1'b1, funct3};
                id_ex_d.wb_sel   = WB_MEM;
                id_ex_d.we       = 1'b1;
            end
            OPC_STORE: begin
                id_ex_d.op2_sel   = 1'b1;
                imm_sel           = IMM_S;
                id_ex_d.mem_write = {1'b1, funct3[1:0]};
            end
            OPC_OP_IMM: begin
                // instr[30] is an immediate bit except for SRLI/SRAI
                id_ex_d.op2_sel = 1'b1;
                imm_sel         = IMM_I;
                id_ex_d.alu_sel = alu_sel_e'({1'b0,
                                  (funct3 == 3'b101) & bus.ID_INSTRUCTION[30], funct3});
                id_ex_d.wb_sel  = WB_ALU;
                id_ex_d.we      = 1'b1;
            end
            OPC_OP: begin
                id_ex_d.alu_sel = alu_sel_e'({bus.ID_INSTRUCTION[25],
                                  bus.ID_INSTRUCTION[30], funct3});
                id_ex_d.wb_sel  = WB_ALU;
                id_ex_d.we      = 1'b1;
            end
            default: ;
        endcase
        if (bus.FLUSH) begin
            id_ex_d = '0;
        end
    end

    assign bus.ID_IMMEDIATE_SELECT = imm_sel;
    assign bus.ID_OPERAND1_SELECT  = (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                                     (opcode == OPC_BRANCH);
    assign bus.ID_OPERAND2_SELECT  = (opcode != OPC_OP) && (opcode == OPC_LUI ||
                                     opcode == OPC_AUIPC || opcode == OPC_JAL ||
                                     opcode == OPC_JALR || opcode == OPC_BRANCH ||
                                     opcode == OPC_LOAD || opcode == OPC_STORE ||
                                     opcode == OPC_OP_IMM);

    // ID/EX register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign op1 = id_ex_q.op1_sel ? id_ex_q.pc  : id_ex_q.rs1;
    assign op2 = id_ex_q.op2_sel ? id_ex_q.imm : id_ex_q.rs2;

    rv32im_alu_core u_alu (
        .op1     (op1),
        .op2     (op2),
        .alu_sel (id_ex_q.alu_sel),
        .result  (alu_out)
    );

    // Branch decision compares the register values, not the ALU operands
    always_comb begin
        bj_sig = 1'b0;
        if (id_ex_q.branch[3]) begin
            case (id_ex_q.branch[2:0])
                3'b000:  bj_sig = (id_ex_q.rs1 == id_ex_q.rs2);
                3'b001:  bj_sig = (id_ex_q.rs1 != id_ex_q.rs2);
                3'b010:  bj_sig = 1'b1;
                3'b100:  bj_sig = ($signed(id_ex_q.rs1) <  $signed(id_ex_q.rs2));
                3'b101:  bj_sig = ($signed(id_ex_q.rs1) >= $signed(id_ex_q.rs2));
                3'b110:  bj_sig = (id_ex_q.rs1 <  id_ex_q.rs2);
                3'b111:  bj_sig = (id_ex_q.rs1 >= id_ex_q.rs2);
                default: bj_sig = 1'b0;
            endcase
        end
    end

    assign bus.EX_PC              = id_ex_q.pc;
    assign bus.EX_REG_DATA2       = id_ex_q.rs2;
    assign bus.EX_REG_WRITE_ADDR  = id_ex_q.rd;
    assign bus.EX_REG_WRITE_EN    = id_ex_q.we;
    assign bus.EX_DATA_MEM_WRITE  = id_ex_q.mem_write;
    assign bus.EX_DATA_MEM_READ   = id_ex_q.mem_read;
    assign bus.EX_WB_VALUE_SELECT = id_ex_q.wb_sel;
    assign bus.EX_ALU_OUT         = alu_out;
    assign bus.EX_BJ_SIG          = bj_sig;

endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Directed, table-driven bench for the RV32IM decode/execute slice.
module tb_rv32im_decode_execute;

    logic CLK;
    logic RESET;

    rv32im_decode_execute_if bus_if ();

    rv32im_decode_execute dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] e_alu;
        logic        e_bj;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [1:0]  e_wb;
        logic [2:0]  e_mw;
        logic [3:0]  e_mr;
        logic [2:0]  e_isel;
        logic        e_s1;
        logic        e_s2;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string name, input logic [31:0] instr, pc, rs1, rs2, imm,
                       input logic [31:0] e_alu, input logic e_bj, input logic e_we,
                       input logic [4:0] e_rd, input logic [1:0] e_wb, input logic [2:0] e_mw,
                       input logic [3:0] e_mr, input logic [2:0] e_isel,
                       input logic e_s1, input logic e_s2);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.e_alu = e_alu; v.e_bj = e_bj; v.e_we = e_we; v.e_rd = e_rd; v.e_wb = e_wb;
        v.e_mw = e_mw; v.e_mr = e_mr; v.e_isel = e_isel; v.e_s1 = e_s1; v.e_s2 = e_s2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic flush, input logic [31:0] instr, pc, rs1, rs2, imm);
        bus_if.FLUSH          = flush;
        bus_if.ID_INSTRUCTION = instr;
        bus_if.ID_PC          = pc;
        bus_if.ID_REG_DATA1   = rs1;
        bus_if.ID_REG_DATA2   = rs2;
        bus_if.ID_IMMEDIATE   = imm;
    endtask

    // Every registered field plus the combinational EX results must be zero in a bubble
    task automatic chk_bubble(input string name);
        chk({name, ".pc"},  bus_if.EX_PC, 32'h0);
        chk({name, ".rs2"}, bus_if.EX_REG_DATA2, 32'h0);
        chk({name, ".rd"},  32'(bus_if.EX_REG_WRITE_ADDR), 32'h0);
        chk({name, ".we"},  32'(bus_if.EX_REG_WRITE_EN), 32'h0);
        chk({name, ".mw"},  32'(bus_if.EX_DATA_MEM_WRITE), 32'h0);
        chk({name, ".mr"},  32'(bus_if.EX_DATA_MEM_READ), 32'h0);
        chk({name, ".wb"},  32'(bus_if.EX_WB_VALUE_SELECT), 32'h0);
        chk({name, ".alu"}, bus_if.EX_ALU_OUT, 32'h0);
        chk({name, ".bj"},  32'(bus_if.EX_BJ_SIG), 32'h0);
    endtask

    localparam logic [31:0] ADD_X3 = 32'h002081B3;

    initial begin
        //   name       instr         pc          rs1          rs2          imm          alu          bj we rd wb     mw      mr       isel   s1 s2
        add("add",    32'h002081B3, 32'h0,     32'd5,       32'd7,       32'h0,       32'd12,      0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("sub",    32'h402081B3, 32'h0,     32'd5,       32'd7,       32'h0,       32'hFFFFFFFE,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("beq_t",  32'h00208063, 32'h100,   32'd9,       32'd9,       32'h20,      32'h120,     1, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("beq_nt", 32'h00208063, 32'h100,   32'd9,       32'd8,       32'h20,      32'h120,     0, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("bne",    32'h00209063, 32'h100,   32'd9,       32'd8,       32'h20,      32'h120,     1, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("bltu",   32'h0020E063, 32'h100,   32'hFFFFFFFF,32'd1,       32'h20,      32'h120,     0, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("blt",    32'h0020C063, 32'h100,   32'hFFFFFFFF,32'd1,       32'h20,      32'h120,     1, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("bge",    32'h0020D063, 32'h100,   32'hFFFFFFFF,32'd1,       32'h20,      32'h120,     0, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("bgeu",   32'h0020F063, 32'h100,   32'hFFFFFFFF,32'd1,       32'h20,      32'h120,     1, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b010, 1, 1);
        add("mul",    32'h022081B3, 32'h0,     32'd3,       32'hFFFFFFFE,32'h0,       32'hFFFFFFFA,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("mulh",   32'h022091B3, 32'h0,     32'h80000000,32'd2,       32'h0,       32'hFFFFFFFF,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("mulhsu", 32'h0220A1B3, 32'h0,     32'hFFFFFFFF,32'hFFFFFFFF,32'h0,       32'hFFFFFFFF,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("mulhu",  32'h0220B1B3, 32'h0,     32'h80000000,32'd2,       32'h0,       32'h1,       0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("div0",   32'h0220C1B3, 32'h0,     32'd7,       32'd0,       32'h0,       32'hFFFFFFFF,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("divu0",  32'h0220D1B3, 32'h0,     32'd7,       32'd0,       32'h0,       32'hFFFFFFFF,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("rem0",   32'h0220E1B3, 32'h0,     32'd7,       32'd0,       32'h0,       32'd7,       0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("remu0",  32'h0220F1B3, 32'h0,     32'd7,       32'd0,       32'h0,       32'd7,       0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("divovf", 32'h0220C1B3, 32'h0,     32'h80000000,32'hFFFFFFFF,32'h0,       32'h80000000,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("removf", 32'h0220E1B3, 32'h0,     32'h80000000,32'hFFFFFFFF,32'h0,       32'h0,       0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("div_n",  32'h0220C1B3, 32'h0,     32'hFFFFFFF9,32'd2,       32'h0,       32'hFFFFFFFD,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("rem_n",  32'h0220E1B3, 32'h0,     32'hFFFFFFF9,32'd2,       32'h0,       32'hFFFFFFFF,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 0);
        add("addi",   32'hFFF08193, 32'h0,     32'd5,       32'd7,       32'hFFFFFFFF,32'd4,       0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 1);
        add("addi30", 32'h40008193, 32'h0,     32'd5,       32'd7,       32'h400,     32'h405,     0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 1);
        add("srai",   32'h4040D193, 32'h0,     32'h80000000,32'd7,       32'h404,     32'hF8000000,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 1);
        add("srli",   32'h0040D193, 32'h0,     32'h80000000,32'd7,       32'h4,       32'h08000000,0, 1, 3, 2'b01, 3'b000, 4'b0000, 3'b000, 0, 1);
        add("lui",    32'h123452B7, 32'h0,     32'hDEAD,    32'd7,       32'h12345000,32'h12345000,0, 1, 5, 2'b01, 3'b000, 4'b0000, 3'b011, 0, 1);
        add("auipc",  32'h00001317, 32'h300,   32'hDEAD,    32'd7,       32'h1000,    32'h1300,    0, 1, 6, 2'b01, 3'b000, 4'b0000, 3'b011, 1, 1);
        add("jalr",   32'h000100E7, 32'h200,   32'h1000,    32'd7,       32'h10,      32'h1010,    1, 1, 1, 2'b00, 3'b000, 4'b0000, 3'b000, 0, 1);
        add("sw",     32'h0020A023, 32'h0,     32'h1000,    32'h55,      32'h8,       32'h1008,    0, 0, 0, 2'b00, 3'b110, 4'b0000, 3'b001, 0, 1);
        add("lw",     32'h0040A203, 32'h0,     32'h1000,    32'h55,      32'h4,       32'h1004,    0, 1, 4, 2'b10, 3'b000, 4'b1010, 3'b000, 0, 1);
        add("lbu",    32'h0040C203, 32'h0,     32'h1000,    32'h55,      32'h4,       32'h1004,    0, 1, 4, 2'b10, 3'b000, 4'b1100, 3'b000, 0, 1);
        add("unk",    32'h0000007F, 32'h0,     32'd5,       32'd7,       32'h0,       32'd12,      0, 0, 0, 2'b00, 3'b000, 4'b0000, 3'b000, 0, 0);

        // Reset dominates a valid instruction on the inputs
        RESET = 1'b1;
        drive(1'b0, ADD_X3, 32'h40, 32'd5, 32'd7, 32'h0);
        @(posedge CLK); #1;
        chk_bubble("reset");
        @(negedge CLK);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge CLK);
            drive(1'b0, v.instr, v.pc, v.rs1, v.rs2, v.imm);
            #1;
            chk({v.name, ".isel"}, 32'(bus_if.ID_IMMEDIATE_SELECT), 32'(v.e_isel));
            chk({v.name, ".s1"},   32'(bus_if.ID_OPERAND1_SELECT), 32'(v.e_s1));
            chk({v.name, ".s2"},   32'(bus_if.ID_OPERAND2_SELECT), 32'(v.e_s2));
            @(posedge CLK); #1;
            chk({v.name, ".alu"},  bus_if.EX_ALU_OUT, v.e_alu);
            chk({v.name, ".bj"},   32'(bus_if.EX_BJ_SIG), 32'(v.e_bj));
            chk({v.name, ".we"},   32'(bus_if.EX_REG_WRITE_EN), 32'(v.e_we));
            chk({v.name, ".rd"},   32'(bus_if.EX_REG_WRITE_ADDR), 32'(v.e_rd));
            chk({v.name, ".wb"},   32'(bus_if.EX_WB_VALUE_SELECT), 32'(v.e_wb));
            chk({v.name, ".mw"},   32'(bus_if.EX_DATA_MEM_WRITE), 32'(v.e_mw));
            chk({v.name, ".mr"},   32'(bus_if.EX_DATA_MEM_READ), 32'(v.e_mr));
            chk({v.name, ".pc"},   bus_if.EX_PC, v.pc);
            chk({v.name, ".rs2"},  bus_if.EX_REG_DATA2, v.rs2);
        end

        // JAL followed by a flushed slot
        @(negedge CLK);
        drive(1'b0, 32'h000000EF, 32'h200, 32'd5, 32'd7, 32'h40);
        #1;
        chk("jal.isel", 32'(bus_if.ID_IMMEDIATE_SELECT), 32'h4);
        @(posedge CLK); #1;
        chk("jal.bj",  32'(bus_if.EX_BJ_SIG), 32'h1);
        chk("jal.wb",  32'(bus_if.EX_WB_VALUE_SELECT), 32'h0);
        chk("jal.alu", bus_if.EX_ALU_OUT, 32'h240);
        chk("jal.we",  32'(bus_if.EX_REG_WRITE_EN), 32'h1);
        chk("jal.rd",  32'(bus_if.EX_REG_WRITE_ADDR), 32'h1);
        @(negedge CLK);
        drive(1'b1, ADD_X3, 32'h204, 32'd5, 32'd7, 32'h0);
        @(posedge CLK); #1;
        chk_bubble("flush");

        // Pipeline resumes after the flush is released
        @(negedge CLK);
        drive(1'b0, ADD_X3, 32'h208, 32'd20, 32'd22, 32'h0);
        @(posedge CLK); #1;
        chk("resume.alu", bus_if.EX_ALU_OUT, 32'd42);
        chk("resume.we",  32'(bus_if.EX_REG_WRITE_EN), 32'h1);

        // Reset asserted together with flush mid-stream
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b1, 32'h0040A203, 32'h20C, 32'h1000, 32'h55, 32'h4);
        @(posedge CLK); #1;
        chk_bubble("reset2");
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
